// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding fetch/data arbiter for one memory port, optional round-robin via ARB_ROUND_ROBIN_EN
module mem_port_arbiter #(
   parameter int XLEN = 32,
   parameter int TO_W = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   // fetch requester
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_adr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [31:0]     if_rdata_o,
   // data requester
   input  logic            d_req_i,
   input  logic [XLEN-1:0] d_adr_i,
   input  logic            d_we_i,
   input  logic [XLEN-1:0] d_wdata_i,
   input  logic [2:0]      d_size_i,
   output logic            d_gnt_o,
   output logic            d_rvalid_o,
   output logic [XLEN-1:0] d_rdata_o,
   // memory side
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_adr_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [2:0]      mem_size_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   // watchdog
   output logic            timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TO_MAX    = '1;
   localparam logic [2:0]      SIZE_WORD = 3'b010;

   state_t          state_q;
   state_t          state_d;
   logic            owner_is_d_q;
   logic [TO_W-1:0] wd_cnt_q;
   logic [XLEN-1:0] adr_q;
   logic            we_q;
   logic [XLEN-1:0] wdata_q;
   logic [2:0]      size_q;

   logic            grant;
   logic            pick_d;
   logic            wd_expired;
   logic            complete;
   logic            timeout_fire;
   logic            rsp_fire;

   // Winner selection among the two requesters, evaluated every cycle
   always_comb begin
      pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      // On contention the side that did not own the previous transaction wins;
      // a lone requester is always served.
      pick_d = d_req_i && (!if_req_i || !owner_is_d_q);
`else
      // Loads/stores always beat instruction fetch.
      pick_d = d_req_i;
`endif
   end

   // Transaction events derived from the current state and memory handshake
   always_comb begin
      grant        = reset_n && (state_q == S_IDLE) && (if_req_i || d_req_i);
      wd_expired   = (state_q != S_IDLE) && (wd_cnt_q == TO_MAX);
      complete     = ((state_q == S_REQ) && mem_gnt_i && mem_rvalid_i) ||
                     ((state_q == S_RSP) && mem_rvalid_i);
      // A real completion in the last watchdog cycle takes precedence.
      timeout_fire = wd_expired && !complete;
      rsp_fire     = reset_n && (complete || timeout_fire);
   end

   // Next-state logic for the request/response sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (complete || timeout_fire) begin
               state_d = S_IDLE;
            end else if (mem_gnt_i) begin
               state_d = S_RSP;
            end
         end
         S_RSP: begin
            if (complete || timeout_fire) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Requester-facing and memory-facing combinational outputs; nothing is
   // handed out while reset is held because that cycle is discarded
   always_comb begin
      if_gnt_o    = grant && !pick_d;
      d_gnt_o     = grant && pick_d;
      if_rvalid_o = rsp_fire && !owner_is_d_q;
      d_rvalid_o  = rsp_fire && owner_is_d_q;
      if_rdata_o  = '0;
      d_rdata_o   = '0;
      if (reset_n && complete) begin
         if (owner_is_d_q) begin
            d_rdata_o = mem_rdata_i;
         end else begin
            if_rdata_o = mem_rdata_i[31:0];
         end
      end
      // Request is withdrawn in the abort cycle so memory never sees a
      // request the arbiter is about to abandon.
      mem_req_o   = reset_n && (state_q == S_REQ) && !wd_expired;
      timeout_o   = reset_n && timeout_fire;
      mem_adr_o   = adr_q;
      mem_we_o    = we_q;
      mem_wdata_o = wdata_q;
      mem_size_o  = size_q;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the winning request fields and owner at grant time
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         owner_is_d_q <= 1'b0;
         adr_q        <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         size_q       <= '0;
      end else if (grant) begin
         owner_is_d_q <= pick_d;
         if (pick_d) begin
            adr_q   <= d_adr_i;
            we_q    <= d_we_i;
            wdata_q <= d_wdata_i;
            size_q  <= d_size_i;
         end else begin
            adr_q   <= if_adr_i;
            we_q    <= 1'b0;
            wdata_q <= '0;
            size_q  <= SIZE_WORD;
         end
      end
   end

   // Watchdog: restarts at each grant and runs while a transaction is open
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wd_cnt_q <= '0;
      end else if (grant) begin
         wd_cnt_q <= '0;
      end else if (state_q != S_IDLE) begin
         wd_cnt_q <= wd_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (TO_W=4), honours ARB_ROUND_ROBIN_EN
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic        if_req_i;
   logic [31:0] if_adr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i;
   logic [31:0] d_adr_i;
   logic        d_we_i;
   logic [31:0] d_wdata_i;
   logic [2:0]  d_size_i;
   logic        d_gnt_o;
   logic        d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_adr_o;
   logic        mem_we_o;
   logic [31:0] mem_wdata_o;
   logic [2:0]  mem_size_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        timeout_o;

   mem_port_arbiter #(.XLEN(32), .TO_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
      .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .timeout_o(timeout_o)
   );

   typedef struct {
      bit          is_if;
      logic [31:0] adr;
      bit          we;
      logic [31:0] wdata;
      logic [2:0]  size;
      int          gap;
   } gnt_exp_t;

   typedef struct {
      bit          is_if;
      logic [31:0] rdata;
      bit          to;
      int          lat;
   } rsp_exp_t;

   gnt_exp_t gq[$];
   rsp_exp_t rq[$];
   gnt_exp_t g_cur;
   rsp_exp_t r_cur;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_gnt_cyc = 0;
   int last_rsp_cyc = 0;
   int probe_zero_cyc = -1;
   int probe_noreq_cyc = -1;
   int probe_norv_cyc = -1;
   int inject_cyc = -1;
   int wd_fails = 0;
   int wd_seen = 0;
   bit done = 0;

   int          gnt_delay = 0;
   int          rsp_delay = 1;
   bit          no_gnt = 0;
   logic [31:0] rsp_data = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a grant, request or response
   always @(negedge clk) begin
      if (if_gnt_o || d_gnt_o) begin
         chk("gnt_onehot", 64'(if_gnt_o & d_gnt_o), 64'(0));
         chk("gnt_without_req", 64'((if_gnt_o & ~if_req_i) | (d_gnt_o & ~d_req_i)), 64'(0));
         chk("gnt_expected", 64'(gq.size() != 0), 64'(1));
         if (gq.size() != 0) begin
            g_cur = gq.pop_front();
            chk("gnt_is_fetch", 64'(if_gnt_o), 64'(g_cur.is_if));
            if (g_cur.gap >= 0) chk("gnt_gap", 64'(cyc - last_rsp_cyc), 64'(g_cur.gap));
         end
         last_gnt_cyc = cyc;
      end
      if (mem_req_o) begin
         chk("mem_adr", 64'(mem_adr_o), 64'(g_cur.adr));
         chk("mem_we", 64'(mem_we_o), 64'(g_cur.we));
         chk("mem_wdata", 64'(mem_wdata_o), 64'(g_cur.wdata));
         chk("mem_size", 64'(mem_size_o), 64'(g_cur.size));
      end
      if (if_rvalid_o || d_rvalid_o) begin
         chk("rvalid_onehot", 64'(if_rvalid_o & d_rvalid_o), 64'(0));
         chk("rsp_expected", 64'(rq.size() != 0), 64'(1));
         if (rq.size() != 0) begin
            r_cur = rq.pop_front();
            chk("rsp_is_fetch", 64'(if_rvalid_o), 64'(r_cur.is_if));
            chk("rsp_rdata", 64'(if_rvalid_o ? if_rdata_o : d_rdata_o), 64'(r_cur.rdata));
            chk("rsp_timeout", 64'(timeout_o), 64'(r_cur.to));
            chk("rsp_latency", 64'(cyc - last_gnt_cyc), 64'(r_cur.lat));
         end
         last_rsp_cyc = cyc;
      end else if (timeout_o) begin
         chk("timeout_without_rvalid", 64'(timeout_o), 64'(0));
      end
      if (cyc == probe_zero_cyc) begin
         chk("zero_ctrl", 64'({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o,
                               mem_we_o, timeout_o, mem_size_o}), 64'(0));
         chk("zero_adr", 64'(mem_adr_o), 64'(0));
         chk("zero_wdata", 64'(mem_wdata_o), 64'(0));
         chk("zero_rdata", {if_rdata_o, d_rdata_o}, 64'(0));
      end
      if (cyc == probe_noreq_cyc) chk("req_after_timeout", 64'(mem_req_o), 64'(0));
      if (cyc == probe_norv_cyc) chk("late_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'(0));
      if (wd_fails != wd_seen) begin
         chk("wait_bound", 64'(wd_fails), 64'(wd_seen));
         wd_seen = wd_fails;
      end
      if (done || cyc >= 5000) begin
         chk("run_complete", 64'(done), 64'(1));
         chk("leftover_gnt", 64'(gq.size()), 64'(0));
         chk("leftover_rsp", 64'(rq.size()), 64'(0));
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   // Memory responder: grants after gnt_delay request cycles, answers rsp_delay cycles later
   initial begin : responder
      int  wcnt;
      int  rcnt;
      bit  busy;
      wcnt = 0; rcnt = 0; busy = 0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(posedge clk); #2;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
         if (!reset_n) begin
            wcnt = 0; rcnt = 0; busy = 0;
         end else if (cyc == inject_cyc) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
         end else if (busy) begin
            rcnt++;
            if (rcnt >= rsp_delay) begin
               mem_rvalid_i = 1'b1; mem_rdata_i = rsp_data; busy = 0;
            end
         end else if (mem_req_o) begin
            if (!no_gnt && wcnt >= gnt_delay) begin
               mem_gnt_i = 1'b1; wcnt = 0;
               if (rsp_delay == 0) begin
                  mem_rvalid_i = 1'b1; mem_rdata_i = rsp_data;
               end else begin
                  busy = 1; rcnt = 0;
               end
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_gnt(input bit is_if, input logic [31:0] adr, input bit we,
                           input logic [31:0] wdata, input logic [2:0] size, input int gap);
      gnt_exp_t e;
      e.is_if = is_if; e.adr = adr; e.we = we; e.wdata = wdata; e.size = size; e.gap = gap;
      gq.push_back(e);
   endtask

   task automatic push_rsp(input bit is_if, input logic [31:0] rdata, input bit to, input int lat);
      rsp_exp_t e;
      e.is_if = is_if; e.rdata = rdata; e.to = to; e.lat = lat;
      rq.push_back(e);
   endtask

   // Waits for a grant to one side; returns one cycle later, optionally dropping the request
   task automatic wait_gnt(input bit is_if, input int budget, input bit drop, output int gcyc);
      int n;
      n = 0;
      gcyc = -1;
      forever begin
         @(negedge clk);
         if (is_if ? if_gnt_o : d_gnt_o) begin
            gcyc = cyc;
            break;
         end
         n++;
         if (n >= budget) begin
            wd_fails++;
            break;
         end
      end
      tick();
      if (drop) begin
         if (is_if) if_req_i = 1'b0;
         else d_req_i = 1'b0;
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (gq.size() != 0 || rq.size() != 0) begin
         @(negedge clk);
         n++;
         if (n >= budget) begin
            wd_fails++;
            break;
         end
      end
      tick();
   endtask

   initial begin : stimulus
      int g;
      reset_n = 1'b0;
      if_req_i = 1'b0; if_adr_i = '0;
      d_req_i = 1'b0; d_adr_i = '0; d_we_i = 1'b0; d_wdata_i = '0; d_size_i = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      probe_zero_cyc = cyc;
      tick();

      // 1: single fetch, memory grants on 2nd request cycle, answers one later
      gnt_delay = 1; rsp_delay = 1; rsp_data = 32'h0000_0013;
      push_gnt(1, 32'h8000_0000, 0, 32'h0, 3'b010, -1);
      push_rsp(1, 32'h0000_0013, 0, 3);
      if_req_i = 1'b1; if_adr_i = 32'h8000_0000;
      wait_gnt(1, 10, 1, g);
      wait_drain(20);

      // 2: contention twice; data keeps requesting with a new address
      gnt_delay = 0; rsp_delay = 1; rsp_data = 32'hA5A5_0001;
      push_gnt(0, 32'h0000_1000, 0, 32'h0, 3'b010, -1);
      push_rsp(0, 32'hA5A5_0001, 0, 2);
`ifdef ARB_ROUND_ROBIN_EN
      push_gnt(1, 32'h0000_0100, 0, 32'h0, 3'b010, 1);
      push_rsp(1, 32'hA5A5_0001, 0, 2);
      push_gnt(0, 32'h0000_1004, 0, 32'h0, 3'b010, 1);
      push_rsp(0, 32'hA5A5_0001, 0, 2);
`else
      push_gnt(0, 32'h0000_1004, 0, 32'h0, 3'b010, 1);
      push_rsp(0, 32'hA5A5_0001, 0, 2);
      push_gnt(1, 32'h0000_0100, 0, 32'h0, 3'b010, 1);
      push_rsp(1, 32'hA5A5_0001, 0, 2);
`endif
      if_req_i = 1'b1; if_adr_i = 32'h0000_0100;
      d_req_i = 1'b1; d_adr_i = 32'h0000_1000; d_we_i = 1'b0; d_wdata_i = '0; d_size_i = 3'b010;
      wait_gnt(0, 10, 0, g);
      d_adr_i = 32'h0000_1004;
`ifdef ARB_ROUND_ROBIN_EN
      wait_gnt(1, 10, 1, g);
      wait_gnt(0, 10, 1, g);
`else
      wait_gnt(0, 10, 1, g);
      wait_gnt(1, 10, 1, g);
`endif
      wait_drain(20);

      // 3: store held three cycles without mem_gnt
      gnt_delay = 3; rsp_delay = 2; rsp_data = 32'h1234_5678;
      push_gnt(0, 32'h0000_2000, 1, 32'hDEAD_BEEF, 3'b010, -1);
      push_rsp(0, 32'h1234_5678, 0, 6);
      d_req_i = 1'b1; d_adr_i = 32'h0000_2000; d_we_i = 1'b1; d_wdata_i = 32'hDEAD_BEEF; d_size_i = 3'b010;
      wait_gnt(0, 10, 1, g);
      d_we_i = 1'b0; d_wdata_i = '0;
      wait_drain(30);

      // 4: memory never grants -> watchdog abort; a pending fetch proves IDLE next cycle
      // 5: that fetch completes with gnt+rvalid together, pending load granted next cycle
      no_gnt = 1; rsp_data = 32'hFFFF_FFFF;
      push_gnt(0, 32'h0000_4000, 0, 32'h0, 3'b001, -1);
      push_rsp(0, 32'h0, 1, 16);
      push_gnt(1, 32'h0000_0500, 0, 32'h0, 3'b010, 1);
      push_rsp(1, 32'hCAFE_F00D, 0, 1);
      push_gnt(0, 32'h0000_6000, 0, 32'h0, 3'b010, 1);
      push_rsp(0, 32'hCAFE_F00D, 0, 1);
      d_req_i = 1'b1; d_adr_i = 32'h0000_4000; d_size_i = 3'b001;
      wait_gnt(0, 10, 1, g);
      probe_noreq_cyc = g + 17;
      if_req_i = 1'b1; if_adr_i = 32'h0000_0500;
      wait_gnt(1, 40, 1, g);
      no_gnt = 0; gnt_delay = 0; rsp_delay = 0; rsp_data = 32'hCAFE_F00D;
      d_req_i = 1'b1; d_adr_i = 32'h0000_6000; d_size_i = 3'b010;
      wait_gnt(0, 10, 1, g);
      wait_drain(20);

      // 6: reset while waiting for the response, then a stray rvalid
      gnt_delay = 0; rsp_delay = 6; rsp_data = 32'h7777_7777;
      push_gnt(1, 32'h0000_0300, 0, 32'h0, 3'b010, -1);
      if_req_i = 1'b1; if_adr_i = 32'h0000_0300;
      wait_gnt(1, 10, 1, g);
      probe_zero_cyc = g + 4;
      inject_cyc = g + 6;
      probe_norv_cyc = g + 6;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (5) tick();

      done = 1'b1;
   end

endmodule
